alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

- Initiator-side companion to the 4-bit ALU.
- Accepts queued commands (two 4-bit operands plus 3-bit opcode) from a host and drives the packed `{B,A}` operand byte and opcode into the ALU.
- Waits a fixed ALU latency, captures the 8-bit result and returns it to the host over a valid/ready handshake.
- Computes the expected result internally and flags any mismatch, serving as both the ALU's feeder and its on-chip checker.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries (power of 2, ≥2)
- `ALU_LAT`, 2: cycles from operand drive to result sample (≥1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  host command present
- `cmd_data`  in  11  `{op[2:0], B[3:0], A[3:0]}`
- `cmd_ready`  out  1  FIFO not full
- `alu_ab`  out  8  `{B,A}` to ALU operand byte
- `alu_op`  out  3  opcode to ALU
- `alu_y`  in  8  ALU result
- `res_valid`  out  1  result held for host
- `res_data`  out  8  captured `alu_y`
- `res_op`  out  3  opcode of the returned result
- `res_mismatch`  out  1  `res_data` ≠ expected; qualified by `res_valid`
- `res_ready`  in  1  host accepts result
- `busy`  out  1  FSM not IDLE or FIFO not empty

## Operation
- **Push:** `cmd_valid & cmd_ready` at an edge writes `cmd_data` into the FIFO. `cmd_ready = (count != DEPTH)`, derived from registered count only. Writes while full are ignored.
- **FSM states:** IDLE, DRIVE, PRESENT.
  - **IDLE:** if FIFO non-empty (registered), pop the head, register `alu_ab`/`alu_op` from it, load `lat_cnt = ALU_LAT-1`, go to DRIVE.
  - **DRIVE:** `alu_ab`/`alu_op` are held. Decrement `lat_cnt`. At `lat_cnt == 0`:
    - register `alu_y` into `res_data`;
    - register the expected value compare into `res_mismatch`;
    - set `res_op`;
    - set `res_valid = 1`;
    - go to PRESENT.
  - **PRESENT:** hold all `res_*` outputs. `res_valid & res_ready` at an edge clears `res_valid` and returns to IDLE. No new issue occurs until back in IDLE, so one command is in flight at most.
- **Expected result:** A and B are zero-extended to 8 bits and the result is 8 bits, wrapping.
  - op0: A+B
  - op1: A−B (mod 256)
  - op2: A&B
  - op3: A|B
  - op4: A^B
  - op5: ~A (8-bit, so upper nibble = 1111)
  - op6: A>>1
  - op7: A<<1
- `alu_ab`/`alu_op` keep their last issued value after completion; they are not cleared.

## Timing
- Reset values: `cmd_ready=1`, `alu_ab=0`, `alu_op=0`, `res_valid=0`, `res_data=0`, `res_op=0`, `res_mismatch=0`, `busy=0`. The FIFO is emptied and the FSM is set to IDLE.
- **Latency:** a command accepted at edge n into an empty FIFO with the FSM in IDLE:
  - is issued (drives `alu_ab`) after edge n+1;
  - has its result sampled at edge n+1+ALU_LAT;
  - shows `res_valid` high from edge n+1+ALU_LAT.
  - Minimum command-to-result latency is ALU_LAT+1 cycles.
- **Throughput:** with `res_ready` tied high, one command per ALU_LAT+2 cycles.
- **Boundary conditions:**
  - Push to an empty FIFO and IDLE in the same cycle: no same-cycle pop; issue follows on the next edge.
  - Push and pop in the same cycle: count is unchanged and the data is not lost.
  - Full: `cmd_ready` is low even if a pop occurs the same cycle.
  - Pointer wrap-around is modulo DEPTH.
  - `res_ready` asserted while `res_valid` is low: ignored.
- **Reset mid-operation:** `rst_n` low at any edge flushes the FIFO, aborts DRIVE and PRESENT, and drops `res_valid`. Pending commands are discarded.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum: ADD, SUB, AND, OR, XOR, NOTA, SHR, SHL = 0..7;
  - `alu_cmd_t` packed struct `{op, b, a}` of 11 bits;
  - `issuer_state_e` enum;
  - a function `alu_expect(a, b, op)` returning 8 bits, shared with the testbench model.
- Sub-module `alu_cmd_fifo`, parameterised by DEPTH and holding `alu_cmd_t` entries, with:
  - push/pop ports;
  - full/empty flags;
  - count;
  - synchronous active-low reset.
- The top-level holds the FSM, latency counter, result register and compare.

## Test plan
- Reset, then push `{op=0,B=3,A=5}` at edge 0 with a model ALU returning the expected value; check:
  - `alu_ab=0x35` after edge 1;
  - `res_valid` high after edge 3;
  - `res_data=0x08`, `res_mismatch=0`.
- Sweep ops with A=3, B=5; require results 0x08, 0xFE, 0x01, 0x07, 0x06, 0xFC, 0x01, 0x06. Separately, A=0xF, op7 → 0x1E.
- Hold `cmd_valid` high for 6 commands with `res_ready=0`; check:
  - `cmd_ready` drops after the 4th accept;
  - no overwrite occurs;
  - releasing `res_ready` drains all commands in order, with FIFO pointers wrapping.
- Model ALU forced to return 0x00 for command A=1, B=1, op0; require `res_data=0x00`, `res_mismatch=1`.
- Hold `res_ready` low 5 cycles in PRESENT; `res_data`/`res_op` stay stable and there is no new `alu_ab` change. On the accept edge, `res_valid` falls and the next command issues one edge later.
- Assert `rst_n=0` for one edge during DRIVE with 3 commands queued; require:
  - all outputs return to reset values;
  - `busy=0`;
  - no stale result appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and expected-result function for the ALU command issuer
package alu_pkg;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      AND  = 3'd2,
      OR   = 3'd3,
      XOR  = 3'd4,
      NOTA = 3'd5,
      SHR  = 3'd6,
      SHL  = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] b;
      logic [3:0] a;
   } alu_cmd_t;

   localparam int CMD_W = $bits(alu_cmd_t);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRIVE   = 2'd1,
      S_PRESENT = 2'd2
   } issuer_state_e;

   // Operands are zero-extended; the 8-bit result wraps.
   function automatic logic [7:0] alu_expect(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic [2:0] op);
      logic [7:0] a8;
      logic [7:0] b8;
      logic [7:0] r;
      a8 = {4'b0000, a};
      b8 = {4'b0000, b};
      case (alu_op_e'(op))
         ADD:     r = a8 + b8;
         SUB:     r = a8 - b8;
         AND:     r = a8 & b8;
         OR:      r = a8 | b8;
         XOR:     r = a8 ^ b8;
         NOTA:    r = ~a8;
         SHR:     r = a8 >> 1;
         SHL:     r = a8 << 1;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO holding alu_cmd_t entries
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [CMD_W-1:0]           push_data,
   input  logic                       pop,
   output logic [CMD_W-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   alu_cmd_t           mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Pointers are PTR_W wide, so wrap-around is the natural modulo-DEPTH overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_push)
         mem[wr_ptr] <= alu_cmd_t'(push_data);
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - feeds queued commands to the ALU, captures and checks results
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [10:0] cmd_data,
   output logic        cmd_ready,
   output logic [7:0]  alu_ab,
   output logic [2:0]  alu_op,
   input  logic [7:0]  alu_y,
   output logic        res_valid,
   output logic [7:0]  res_data,
   output logic [2:0]  res_op,
   output logic        res_mismatch,
   input  logic        res_ready,
   output logic        busy
);

   localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   issuer_state_e           state;
   issuer_state_e           state_nx;
   logic [LAT_W-1:0]        lat_cnt;
   logic                    fifo_pop;
   logic [CMD_W-1:0]        fifo_rd_data;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;
   alu_cmd_t                head;
   logic                    issue;
   logic                    capture;
   logic                    release_res;

   alu_cmd_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_valid),
      .push_data (cmd_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign head      = alu_cmd_t'(fifo_rd_data);
   assign cmd_ready = ~fifo_full;
   assign busy      = (state != S_IDLE) | (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // res_valid is always high in PRESENT, so res_ready alone completes the handshake there.
   always_comb begin
      state_nx    = state;
      fifo_pop    = 1'b0;
      issue       = 1'b0;
      capture     = 1'b0;
      release_res = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               issue    = 1'b1;
               state_nx = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (lat_cnt == '0) begin
               capture  = 1'b1;
               state_nx = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (res_ready) begin
               release_res = 1'b1;
               state_nx    = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lat_cnt      <= '0;
         alu_ab       <= '0;
         alu_op       <= '0;
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_op       <= '0;
         res_mismatch <= 1'b0;
      end else begin
         if (issue) begin
            alu_ab  <= {head.b, head.a};
            alu_op  <= head.op;
            lat_cnt <= LAT_W'(ALU_LAT - 1);
         end else if (state == S_DRIVE && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
         end
         // alu_ab/alu_op still hold the in-flight command, so they feed the checker directly.
         if (capture) begin
            res_data     <= alu_y;
            res_op       <= alu_op;
            res_mismatch <= (alu_y != alu_expect(alu_ab[3:0], alu_ab[7:4], alu_op));
            res_valid    <= 1'b1;
         end else if (release_res) begin
            res_valid    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic [10:0] cmd_data;
   logic        cmd_ready;
   logic [7:0]  alu_ab;
   logic [2:0]  alu_op;
   logic [7:0]  alu_y;
   logic        res_valid;
   logic [7:0]  res_data;
   logic [2:0]  res_op;
   logic        res_mismatch;
   logic        res_ready;
   logic        busy;

   int          checks = 0;
   int          failures = 0;
   logic        force_bad = 1'b0;
   logic [7:0]  sweep_exp [8] = '{8'h08, 8'hFE, 8'h01, 8'h07, 8'h06, 8'hFC, 8'h01, 8'h06};
   logic [10:0] q [$];

   always #5 clk = ~clk;

   alu_cmd_issuer #(
      .DEPTH   (4),
      .ALU_LAT (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_data     (cmd_data),
      .cmd_ready    (cmd_ready),
      .alu_ab       (alu_ab),
      .alu_op       (alu_op),
      .alu_y        (alu_y),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .res_op       (res_op),
      .res_mismatch (res_mismatch),
      .res_ready    (res_ready),
      .busy         (busy)
   );

   function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
      int r;
      case (op)
         3'd0:    r = int'(a) + int'(b);
         3'd1:    r = 256 + int'(a) - int'(b);
         3'd2:    r = int'(a & b);
         3'd3:    r = int'(a | b);
         3'd4:    r = int'(a ^ b);
         3'd5:    r = 255 - int'(a);
         3'd6:    r = int'(a) / 2;
         3'd7:    r = int'(a) * 2;
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   // Model ALU: correct answers, except one deliberately wrong result when force_bad is set.
   assign alu_y = (force_bad && alu_ab == 8'h11 && alu_op == 3'd0) ? 8'h00
                : ref_alu(alu_ab[3:0], alu_ab[7:4], alu_op);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_res(input string tag);
      int n = 0;
      while (!res_valid && n < 30) begin
         step();
         n++;
      end
      chk({tag, "_timeout"}, 32'(res_valid), 32'd1);
   endtask

   task automatic accept_res();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("res_valid_drop", 32'(res_valid), 32'd0);
   endtask

   task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input logic [7:0] exp, input logic exp_mm);
      cmd_data  = {op, b, a};
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      wait_res(tag);
      chk({tag, "_data"}, 32'(res_data), 32'(exp));
      chk({tag, "_op"}, 32'(res_op), 32'(op));
      chk({tag, "_mm"}, 32'(res_mismatch), 32'(exp_mm));
      accept_res();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_alu_ab"}, 32'(alu_ab), 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_data"}, 32'(res_data), 32'd0);
      chk({tag, "_res_op"}, 32'(res_op), 32'd0);
      chk({tag, "_res_mm"}, 32'(res_mismatch), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [2:0]  rop;
      logic [10:0] c;
      logic [7:0]  held_data;
      logic [2:0]  held_op;
      logic [7:0]  held_ab;
      int          accepts;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      res_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      chk_reset_state("reset");

      // First command: latency from accept edge to issue and to result.
      cmd_data  = {3'd0, 4'd3, 4'd5};
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("lat_e0_ab", 32'(alu_ab), 32'h00);
      chk("lat_e0_busy", 32'(busy), 32'd1);
      step();
      chk("lat_e1_ab", 32'(alu_ab), 32'h35);
      chk("lat_e1_valid", 32'(res_valid), 32'd0);
      step();
      chk("lat_e2_valid", 32'(res_valid), 32'd0);
      step();
      chk("lat_e3_valid", 32'(res_valid), 32'd1);
      chk("lat_e3_data", 32'(res_data), 32'h08);
      chk("lat_e3_mm", 32'(res_mismatch), 32'd0);
      accept_res();

      // res_ready with nothing to return must not disturb anything.
      res_ready = 1'b1;
      step();
      step();
      res_ready = 1'b0;
      chk("idle_ready_valid", 32'(res_valid), 32'd0);
      chk("idle_ready_busy", 32'(busy), 32'd0);

      for (int op = 0; op < 8; op++)
         run_one($sformatf("sweep_op%0d", op), 4'd3, 4'd5, 3'(op), sweep_exp[op], 1'b0);
      run_one("shl_f", 4'hF, 4'h0, 3'd7, 8'h1E, 1'b0);

      for (int i = 0; i < 10; i++) begin
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         rop = 3'($urandom_range(0, 7));
         run_one($sformatf("rand%0d", i), ra, rb, rop, ref_alu(ra, rb, rop), 1'b0);
      end

      force_bad = 1'b1;
      run_one("mismatch", 4'd1, 4'd1, 3'd0, 8'h00, 1'b1);
      force_bad = 1'b0;

      // Park one result in PRESENT, then try to push six commands into the FIFO.
      cmd_data  = {3'd2, 4'hC, 4'hA};
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      wait_res("fill_head");
      held_data = res_data;
      held_op   = res_op;
      held_ab   = alu_ab;
      chk("fill_head_data", 32'(held_data), 32'h08);
      accepts = 0;
      for (int i = 0; i < 6; i++) begin
         c = 11'($urandom);
         cmd_data  = c;
         cmd_valid = 1'b1;
         chk($sformatf("fill_ready%0d", i), 32'(cmd_ready), 32'(accepts < 4));
         if (accepts < 4) begin
            q.push_back(c);
            accepts++;
         end
         step();
         chk($sformatf("hold_valid%0d", i), 32'(res_valid), 32'd1);
         chk($sformatf("hold_data%0d", i), 32'(res_data), 32'(held_data));
         chk($sformatf("hold_op%0d", i), 32'(res_op), 32'(held_op));
         chk($sformatf("hold_ab%0d", i), 32'(alu_ab), 32'(held_ab));
      end
      cmd_valid = 1'b0;
      chk("fill_full_ready", 32'(cmd_ready), 32'd0);
      chk("fill_busy", 32'(busy), 32'd1);

      accept_res();
      chk("accept_ab_held", 32'(alu_ab), 32'(held_ab));
      step();
      chk("issue_after_accept", 32'(alu_ab), 32'(q[0][7:0]));
      while (q.size() > 0) begin
         c = q.pop_front();
         wait_res("drain");
         chk("drain_ab", 32'(alu_ab), 32'(c[7:0]));
         chk("drain_data", 32'(res_data), 32'(ref_alu(c[3:0], c[7:4], c[10:8])));
         chk("drain_op", 32'(res_op), 32'(c[10:8]));
         chk("drain_mm", 32'(res_mismatch), 32'd0);
         accept_res();
      end
      step();
      chk("drain_idle_busy", 32'(busy), 32'd0);

      // Reset while the first of three queued commands is in DRIVE.
      for (int i = 0; i < 3; i++) begin
         cmd_data  = 11'($urandom);
         cmd_valid = 1'b1;
         if (i == 0)
            c = cmd_data;
         step();
      end
      cmd_valid = 1'b0;
      chk("pre_rst_ab", 32'(alu_ab), 32'(c[7:0]));
      chk("pre_rst_valid", 32'(res_valid), 32'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_reset_state("midrst");
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("post_rst_valid%0d", i), 32'(res_valid), 32'd0);
         chk($sformatf("post_rst_busy%0d", i), 32'(busy), 32'd0);
      end
      run_one("after_rst", 4'd9, 4'd4, 3'd1, 8'h05, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
